// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and capture-side types, common to the
// timing controller and the capture block.
package vga_pkg;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_START  = 48;
  localparam int H_ACTIVE = 640;
  localparam int V_START  = 33;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} cap_state_t;
  typedef logic [11:0] pixel_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// Registers a 1-bit sync input and flags its rising edge
// (the end of the active-low sync pulse).
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic rise
);
  logic sync_q;
  logic sync_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= sync;
      sync_d <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_d;
endmodule

// File: rtl/vga_capture.sv
// VGA receiver: recovers row/column from hs/vs edges, qualifies line and frame
// lengths to declare lock, and writes active pixels into a frame RAM while locked.
module vga_capture #(
  parameter int H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int H_START  = vga_pkg::H_START,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_START  = vga_pkg::V_START,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        wr_en,
  output logic [8:0]  wr_row,
  output logic [9:0]  wr_col,
  output logic [11:0] wr_data,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err
);
  import vga_pkg::*;

  // h_cnt reads 0 one cycle after the hs_rise cycle, so it trails the
  // registered pixel position by one; the column window is shifted to match.
  localparam int COL_LO = H_START - 1;

  logic       hs_rise;
  logic       vs_rise;
  pixel_t     rgb_q;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] line_count;
  logic       v_pend;
  logic       frame_err;
  cap_state_t state;

  logic [10:0] h_len;
  logic        line_bad;
  logic        frame_ok;
  logic        h_timeout;
  logic        in_rows;
  logic        in_cols;
  logic        wr_now;

  vga_sync_edge u_hs_edge (.clk(clk), .rst(rst), .sync(hs), .rise(hs_rise));
  vga_sync_edge u_vs_edge (.clk(clk), .rst(rst), .sync(vs), .rise(vs_rise));

  assign h_len     = {1'b0, h_cnt} + 11'd1;
  assign line_bad  = hs_rise && (h_len != 11'(H_TOTAL));
  assign frame_ok  = (line_count == 10'(V_TOTAL));
  assign h_timeout = (h_cnt == 10'h3FF);
  assign in_rows   = (v_cnt >= 10'(V_START)) && (v_cnt < 10'(V_START + V_ACTIVE));
  assign in_cols   = (h_cnt >= 10'(COL_LO)) && (h_cnt < 10'(COL_LO + H_ACTIVE));
  assign wr_now    = (state == LOCKED) && in_rows && in_cols;

  // Input register and line/frame position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q      <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      line_count <= '0;
      v_pend     <= 1'b0;
    end else begin
      rgb_q <= {r, g, b};
      if (hs_rise)
        h_cnt <= '0;
      else
        h_cnt <= sat_inc10(h_cnt);
      if (vs_rise) begin
        v_cnt      <= '0;
        v_pend     <= ~hs_rise;
        line_count <= hs_rise ? 10'd1 : 10'd0;
      end else if (hs_rise) begin
        v_cnt      <= v_pend ? 10'd0 : sat_inc10(v_cnt);
        v_pend     <= 1'b0;
        line_count <= sat_inc10(line_count);
      end
    end
  end

  // Lock FSM with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (h_timeout) begin
        sync_err <= (state == LOCKED);
        state    <= SEARCH;
        locked   <= 1'b0;
      end else begin
        case (state)
          SEARCH: begin
            if (vs_rise) begin
              state     <= TRACK;
              frame_err <= line_bad;
            end
          end
          TRACK: begin
            if (vs_rise) begin
              if (!frame_err && !line_bad && frame_ok) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                frame_start <= 1'b1;
              end else begin
                frame_err <= line_bad;
              end
            end else if (line_bad) begin
              frame_err <= 1'b1;
            end
          end
          LOCKED: begin
            if (line_bad || (vs_rise && !frame_ok)) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              sync_err <= 1'b1;
            end else if (vs_rise) begin
              frame_start <= 1'b1;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pixel RAM write port; address and data hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= wr_now;
      if (wr_now) begin
        wr_row  <= 9'(v_cnt - 10'(V_START));
        wr_col  <= h_cnt - 10'(COL_LO);
        wr_data <= rgb_q;
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a scaled-down raster (100x27 with the same
// sync/porch structure) so many frames fit in a short run.
module tb_vga_capture;
  localparam int HT = 100, HSW = 12, HS = 8, HA = 72;
  localparam int VT = 27,  VSW = 2,  VS = 3, VA = 20;

  logic        clk = 1'b0;
  logic        rst, hs, vs;
  logic [3:0]  r, g, b;
  logic        wr_en, frame_start, locked, sync_err;
  logic [8:0]  wr_row;
  logic [9:0]  wr_col;
  logic [11:0] wr_data;

  vga_capture #(.H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .H_ACTIVE(HA),
                .V_START(VS), .V_ACTIVE(VA)) dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder and write scoreboard (expected raster order after frame_start)
  int wcount = 0, sb_bad = 0, r5cnt = 0, se_cnt = 0, se_cyc = -1, fs_cnt = 0, fs_cyc = -1;
  int lk_rises = 0, lk_rise_cyc = -1, lk_fall_cyc = -1, exp_r = 0, exp_c = 0;
  logic arm = 1'b0, lk_prev = 1'b0;
  logic [8:0]  first_row = '1;
  logic [9:0]  first_col = '1;
  logic [11:0] first_data = '1;

  always @(negedge clk) begin
    if (frame_start === 1'b1) begin fs_cnt++; fs_cyc = cyc; arm = 1'b1; exp_r = 0; exp_c = 0; end
    if (sync_err === 1'b1) begin se_cnt++; se_cyc = cyc; end
    if (locked === 1'b1 && !lk_prev) begin lk_rises++; lk_rise_cyc = cyc; end
    if (locked !== 1'b1 && lk_prev) lk_fall_cyc = cyc;
    lk_prev = (locked === 1'b1);
    if (wr_en === 1'b1) begin
      wcount++;
      if (arm) begin first_row = wr_row; first_col = wr_col; first_data = wr_data; arm = 1'b0; end
      if (wr_row !== 9'(exp_r) || wr_col !== 10'(exp_c) || wr_data !== {exp_r[3:0], exp_c[7:0]})
        sb_bad++;
      if (wr_row == 9'd5) r5cnt++;
      if (exp_c == HA - 1) begin exp_c = 0; exp_r++; end else exp_c++;
    end
  end

  int nvec = 0, nerr = 0;
  int vs_cyc = -1, mark_line = -1, mark_cyc = -1;
  int w0, se0, fs0, lr0, r50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int ln, input int hc);
    int row, col;
    row = ln - VSW - VS;
    col = hc - HSW - HS;
    if (row >= 0 && row < VA && col >= 0 && col < HA) return {row[3:0], col[7:0]};
    return 12'h000;
  endfunction

  task automatic drive_line(input int ln, input int hc_lo, input int hc_hi);
    for (int hc = hc_lo; hc < hc_hi; hc++) begin
      @(posedge clk); #1;
      hs = (hc >= HSW);
      vs = (ln >= VSW);
      {r, g, b} = pix(ln, hc);
      if (ln == VSW && hc == 0) vs_cyc = cyc;
      if (ln == mark_line && hc == HSW) mark_cyc = cyc;
    end
  endtask

  task automatic drive_frame(input int nlines, input int short_ln);
    for (int ln = 0; ln < nlines; ln++)
      drive_line(ln, 0, (ln == short_ln) ? HT - 1 : HT);
  endtask

  initial begin
    rst = 1'b1; hs = 1'b0; vs = 1'b0; r = '0; g = '0; b = '0;
    @(posedge clk); #1;
    chk("reset_wr_en", 32'(wr_en), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_frame_start", 32'(frame_start), 0);
    chk("reset_sync_err", 32'(sync_err), 0);
    rst = 1'b0;

    // Acquire lock over two nominal frames
    drive_frame(VT, -1);
    chk("track_not_locked", 32'(locked), 0);
    w0 = wcount; r50 = r5cnt;
    drive_frame(VT, -1);
    chk("lock_rise_cycle", lk_rise_cyc, vs_cyc + 2);
    chk("frame_start_cycle", fs_cyc, vs_cyc + 2);
    chk("locked_after_2nd_vs", 32'(locked), 1);
    chk("writes_frame2", wcount - w0, HA * VA);
    chk("first_row", 32'(first_row), 0);
    chk("first_col", 32'(first_col), 0);
    chk("first_data", 32'(first_data), 32'h000);
    chk("last_row", 32'(wr_row), 19);
    chk("last_col", 32'(wr_col), 71);
    chk("last_data", 32'(wr_data), 32'h347);
    chk("scoreboard_frame2", sb_bad, 0);
    chk("row5_writes", r5cnt - r50, HA);

    w0 = wcount; se0 = se_cnt; fs0 = fs_cnt;
    drive_frame(VT, -1);
    chk("writes_frame3", wcount - w0, HA * VA);
    chk("no_sync_err_nominal", se_cnt - se0, 0);
    chk("frame_start_count", fs_cnt - fs0, 1);
    chk("scoreboard_frame3", sb_bad, 0);

    // Reset asserted mid-line while writing
    for (int ln = 0; ln < 10; ln++) drive_line(ln, 0, HT);
    drive_line(10, 0, 40);
    chk("pre_reset_locked", 32'(locked), 1);
    chk("pre_reset_wr_en", 32'(wr_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_frame_start", 32'(frame_start), 0);
    chk("midrst_sync_err", 32'(sync_err), 0);
    chk("midrst_wr_data", 32'(wr_data), 0);
    #1 rst = 1'b0;
    lr0 = lk_rises; w0 = wcount;
    drive_line(10, 40, HT);
    for (int ln = 11; ln < VT; ln++) drive_line(ln, 0, HT);
    drive_frame(VT, -1);
    chk("rst_1st_vs_unlocked", 32'(locked), 0);
    chk("rst_no_writes", wcount - w0, 0);
    drive_frame(VT, -1);
    chk("rst_relock_cycle", lk_rise_cyc, vs_cyc + 2);
    chk("rst_relock_count", lk_rises - lr0, 1);
    chk("rst_relocked", 32'(locked), 1);

    // One line of 99 clocks while locked
    w0 = wcount; se0 = se_cnt; mark_line = 11;
    drive_frame(VT, 10);
    mark_line = -1;
    chk("short_line_sync_err_count", se_cnt - se0, 1);
    chk("short_line_sync_err_cycle", se_cyc, mark_cyc + 2);
    chk("short_line_lock_fall", lk_fall_cyc, mark_cyc + 2);
    chk("short_line_unlocked", 32'(locked), 0);
    chk("short_line_writes", wcount - w0, 6 * HA);
    w0 = wcount;
    drive_frame(VT, -1);
    chk("short_line_track", 32'(locked), 0);
    chk("short_line_no_writes", wcount - w0, 0);
    w0 = wcount;
    drive_frame(VT, -1);
    chk("short_line_relock_cycle", lk_rise_cyc, vs_cyc + 2);
    chk("short_line_relock_writes", wcount - w0, HA * VA);
    chk("scoreboard_relock", sb_bad, 0);

    // Frame one line short while locked
    w0 = wcount; se0 = se_cnt;
    drive_frame(VT - 1, -1);
    chk("short_frame_writes", wcount - w0, HA * VA);
    chk("short_frame_still_locked", 32'(locked), 1);
    w0 = wcount;
    drive_frame(VT, -1);
    chk("short_frame_sync_err_count", se_cnt - se0, 1);
    chk("short_frame_sync_err_cycle", se_cyc, vs_cyc + 2);
    chk("short_frame_unlocked", 32'(locked), 0);
    chk("short_frame_no_writes", wcount - w0, 0);
    drive_frame(VT, -1);
    chk("short_frame_next_unlocked", 32'(locked), 0);
    drive_frame(VT, -1);
    chk("short_frame_relock_cycle", lk_rise_cyc, vs_cyc + 2);
    chk("short_frame_relocked", 32'(locked), 1);

    // hs stuck high for 1100 clocks in row 1
    for (int ln = 0; ln < 6; ln++) drive_line(ln, 0, HT);
    w0 = wcount; se0 = se_cnt; mark_line = 6;
    drive_line(6, 0, HSW + 1100);
    mark_line = -1;
    chk("timeout_sync_err_count", se_cnt - se0, 1);
    chk("timeout_sync_err_cycle", se_cyc, mark_cyc + 1026);
    chk("timeout_lock_fall", lk_fall_cyc, mark_cyc + 1026);
    chk("timeout_unlocked", 32'(locked), 0);
    chk("timeout_writes_only_row1", wcount - w0, HA);
    chk("scoreboard_final", sb_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
